// File: rtl/bus_pkg.sv
// Shared bus codes, sequencer state encoding and request legality helpers.
// The bus mux imports the same source constants so both sides agree on codes.
package bus_pkg;

  localparam logic [3:0] SRC_NONE = 4'd0;
  localparam logic [3:0] SRC_IR   = 4'd4;
  localparam logic [3:0] SRC_AC   = 4'd5;
  localparam logic [3:0] SRC_R1   = 4'd7;
  localparam logic [3:0] SRC_R2   = 4'd8;
  localparam logic [3:0] SRC_R3   = 4'd9;
  localparam logic [3:0] SRC_R4   = 4'd10;
  localparam logic [3:0] SRC_DM   = 4'd12;
  localparam logic [3:0] SRC_IM   = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic is_legal_src(input logic [3:0] code);
    return code inside {SRC_IR, SRC_AC, SRC_R1, SRC_R2, SRC_R3, SRC_R4, SRC_DM, SRC_IM};
  endfunction

  // IM is read-only, so it never appears as a destination.
  function automatic logic is_legal_dst(input logic [3:0] code);
    return code inside {SRC_IR, SRC_AC, SRC_R1, SRC_R2, SRC_R3, SRC_R4, SRC_DM};
  endfunction

  function automatic logic is_mem_src(input logic [3:0] code);
    return (code == SRC_DM) || (code == SRC_IM);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: drives the source select, waits out memory latency,
// then strobes a one-hot destination write enable.
//
//   state | meaning
//   IDLE  | bus idle, ready for a request
//   SETUP | source select driven, bus settling
//   WAIT  | extra MEM_LAT cycles for DM/IM sources
//   WRITE | destination strobe and done pulse
//   ERR   | rejected request, err pulse
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int WE_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_src,
  input  logic [3:0]      req_dst,
  output logic [3:0]      read_en,
  output logic [WE_W-1:0] write_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q;
  logic [3:0]      src_q;
  logic [3:0]      dst_q;
  logic [3:0]      cnt_q;
  logic [3:0]      read_en_q;
  logic [WE_W-1:0] write_en_q;
  logic            done_q;
  logic            err_q;
  logic            req_legal;

  assign req_legal = is_legal_src(req_src) && is_legal_dst(req_dst) && (req_src != req_dst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      read_en_q  <= SRC_NONE;
      write_en_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          write_en_q <= '0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          read_en_q  <= SRC_NONE;
          if (req_valid) begin
            src_q <= req_src;
            dst_q <= req_dst;
            if (req_legal) begin
              state_q   <= ST_SETUP;
              read_en_q <= req_src;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (is_mem_src(src_q) && (MEM_LAT > 0)) begin
            state_q <= ST_WAIT;
            cnt_q   <= 4'(MEM_LAT - 1);
          end else begin
            state_q    <= ST_WRITE;
            write_en_q <= WE_W'(1) << dst_q;
            done_q     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= ST_WRITE;
            write_en_q <= WE_W'(1) << dst_q;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WRITE: begin
          state_q    <= ST_IDLE;
          read_en_q  <= SRC_NONE;
          write_en_q <= '0;
          done_q     <= 1'b0;
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          read_en_q  <= SRC_NONE;
          write_en_q <= '0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign read_en   = read_en_q;
  assign write_en  = write_en_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: one instance with MEM_LAT=2, one with MEM_LAT=0.
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_src = '0, a_dst = '0, b_src = '0, b_dst = '0;
  logic        a_ready, b_ready, a_busy, b_busy, a_done, b_done, a_err, b_err;
  logic [3:0]  a_rd, b_rd;
  logic [15:0] a_we, b_we;

  bus_xfer_ctrl #(.MEM_LAT(2), .WE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_src(a_src), .req_dst(a_dst), .read_en(a_rd), .write_en(a_we),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  bus_xfer_ctrl #(.MEM_LAT(0), .WE_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_src(b_src), .req_dst(b_dst), .read_en(b_rd), .write_en(b_we),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] we;
    logic        done;
    logic        err;
    logic        ready;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_legal_src(input int s);
    return s inside {4, 5, 7, 8, 9, 10, 12, 13};
  endfunction

  function automatic bit m_legal_dst(input int d);
    return d inside {4, 5, 7, 8, 9, 10, 12};
  endfunction

  task automatic push_exp(input int rd, input int we, input bit dn, input bit er, input bit rdy);
    exp_t e;
    e.rd    = 4'(rd);
    e.we    = 16'(we);
    e.done  = dn;
    e.err   = er;
    e.ready = rdy;
    e.busy  = ~rdy;
    sb_q.push_back(e);
  endtask

  // Expected per-cycle outputs for cycles 1.. after the accept edge.
  task automatic push_model(input int s, input int d, input int lat);
    if (m_legal_src(s) && m_legal_dst(d) && s != d) begin
      push_exp(s, 0, 0, 0, 0);
      if (s == 12 || s == 13)
        for (int i = 0; i < lat; i++) push_exp(s, 0, 0, 0, 0);
      push_exp(s, 1 << d, 1, 0, 0);
    end else begin
      push_exp(0, 0, 0, 1, 0);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(0, 0, 0, 0, 1);
  endtask

  task automatic check_cycles(input int which, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(n - i), 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (which == 0) begin
          chk("read_en", 32'(a_rd), 32'(e.rd));
          chk("write_en", 32'(a_we), 32'(e.we));
          chk("done", 32'(a_done), 32'(e.done));
          chk("err", 32'(a_err), 32'(e.err));
          chk("req_ready", 32'(a_ready), 32'(e.ready));
          chk("busy", 32'(a_busy), 32'(e.busy));
        end else begin
          chk("lat0_read_en", 32'(b_rd), 32'(e.rd));
          chk("lat0_write_en", 32'(b_we), 32'(e.we));
          chk("lat0_done", 32'(b_done), 32'(e.done));
          chk("lat0_err", 32'(b_err), 32'(e.err));
          chk("lat0_req_ready", 32'(b_ready), 32'(e.ready));
          chk("lat0_busy", 32'(b_busy), 32'(e.busy));
        end
      end
    end
  endtask

  // Drives one request, lets it be accepted, then scrambles the inputs.
  task automatic send(input int which, input int s, input int d);
    @(negedge clk);
    if (which == 0) begin
      a_valid = 1'b1; a_src = 4'(s); a_dst = 4'(d);
      chk("ready_before_accept", 32'(a_ready), 32'd1);
    end else begin
      b_valid = 1'b1; b_src = 4'(s); b_dst = 4'(d);
      chk("lat0_ready_before_accept", 32'(b_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_src = 4'd15; a_dst = 4'd9;
    b_valid = 1'b0; b_src = 4'd15; b_dst = 4'd9;
  endtask

  initial begin
    #12;
    chk("rst_read_en", 32'(a_rd), 32'd0);
    chk("rst_write_en", 32'(a_we), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_lat0_write_en", 32'(b_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // register move AC -> R1
    send(0, 5, 7);
    push_model(5, 7, 2); push_idle(1);
    check_cycles(0, 3);

    // memory source DM -> AC
    send(0, 12, 5);
    push_model(12, 5, 2); push_idle(1);
    check_cycles(0, 5);

    // illegal: bad src, IM as dst, src == dst, DM -> DM
    send(0, 6, 5);   push_model(6, 5, 2);   push_idle(1); check_cycles(0, 2);
    send(0, 5, 13);  push_model(5, 13, 2);  push_idle(1); check_cycles(0, 2);
    send(0, 8, 8);   push_model(8, 8, 2);   push_idle(1); check_cycles(0, 2);
    send(0, 12, 12); push_model(12, 12, 2); push_idle(1); check_cycles(0, 2);

    // back-to-back with req_valid held; inputs swapped while busy
    @(negedge clk);
    a_valid = 1'b1; a_src = 4'd7; a_dst = 4'd8;
    @(posedge clk);
    #1;
    a_src = 4'd9; a_dst = 4'd10;
    push_model(7, 8, 2); push_idle(1);
    check_cycles(0, 3);
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_src = 4'd4; a_dst = 4'd4;
    push_model(9, 10, 2); push_idle(1);
    check_cycles(0, 3);

    // reset while waiting on IM
    send(0, 13, 4);
    push_model(13, 4, 2);
    check_cycles(0, 2);
    sb_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_read_en", 32'(a_rd), 32'd0);
    chk("midrst_write_en", 32'(a_we), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_done", 32'(a_done), 32'd0);
    chk("midrst_err", 32'(a_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_write_en", 32'(a_we), 32'd0);
    end
    rst_n = 1'b1;
    push_idle(3);
    check_cycles(0, 3);

    // MEM_LAT = 0 instance: IM -> IR skips WAIT
    send(1, 13, 4);
    push_model(13, 4, 0); push_idle(1);
    check_cycles(1, 3);
    send(1, 7, 5);
    push_model(7, 5, 0); push_idle(1);
    check_cycles(1, 3);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
